// File: rtl/command_encoder.sv
// Command encoder: queues {opcode, command} entries and serialises each one as a 1-byte (short)
// or 5-byte (long) frame to a UART transmitter over a trans_en / tx_busy handshake.
module command_encoder #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  opcode,
    input  logic [31:0] command,
    output logic [7:0]  byte_out,
    output logic        trans_en,
    input  logic        tx_busy,
    output logic        frame_done,
    output logic        busy
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StWaitBusy, StWaitDone} state_e;

    state_e          state_q, state_d;
    logic [39:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [31:0]     frame_q, frame_d;
    logic [2:0]      left_q, left_d;
    logic [7:0]      byte_q, byte_d;
    logic [39:0]     head;
    logic            push, pop;

    assign cmd_ready = (count_q != FullCount);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0) && !tx_busy;
    assign head      = mem_q[rd_ptr_q];
    assign byte_out  = byte_q;
    assign busy      = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {command, opcode};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // frame_q holds the not-yet-sent argument bytes, least significant first.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        left_d     = left_q;
        byte_d     = byte_q;
        trans_en   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    frame_d = head[39:8];
                    left_d  = head[7] ? 3'd5 : 3'd1;
                    byte_d  = head[7:0];
                    state_d = StSend;
                end
            end
            StSend: begin
                trans_en = 1'b1;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    left_d = left_q - 3'd1;
                    if (left_q != 3'd1) begin
                        byte_d  = frame_q[7:0];
                        frame_d = {8'h00, frame_q[31:8]};
                        state_d = StSend;
                    end else begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            frame_q  <= '0;
            left_q   <= '0;
            byte_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            frame_q <= frame_d;
            left_q  <= left_d;
            byte_q  <= byte_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule
